// File: rtl/shifter_pkg.sv
// Shared opcode encoding and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SLL = 3'b000;
    localparam op_t OP_SRL = 3'b001;
    localparam op_t OP_SRA = 3'b010;
    localparam op_t OP_ROL = 3'b011;
    localparam op_t OP_ROR = 3'b100;

    // Latency and capacity of a shifter equal the number of registered stages.
    function automatic int popcount(input logic [31:0] mask);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One log stage of the barrel shifter: shift by DIST when the matching shamt bit is set,
// optionally followed by a one-entry slot register with valid/ready flow control.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int TAG_W      = 5,
    parameter int DIST       = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic [2:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH)-1:0]   out_shamt,
    output logic [2:0]                 out_op,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int BIT     = $clog2(DIST);

    function automatic logic [WIDTH-1:0] shift_dist(input logic [WIDTH-1:0] d, input op_t op);
        logic signed [WIDTH-1:0] d_s;
        d_s = d;
        case (op)
            OP_SLL:  return d << DIST;
            OP_SRL:  return d >> DIST;
            OP_SRA:  return $unsigned(d_s >>> DIST);
            OP_ROL:  return {d[WIDTH-1-DIST:0], d[WIDTH-1 -: DIST]};
            OP_ROR:  return {d[DIST-1:0], d[WIDTH-1:DIST]};
            default: return d;
        endcase
    endfunction

    logic [WIDTH-1:0] shifted;
    assign shifted = in_shamt[BIT] ? shift_dist(in_data, in_op) : in_data;

    if (REGISTERED) begin : g_reg
        logic               vld_q,   vld_d;
        logic [WIDTH-1:0]   data_q,  data_d;
        logic [SHAMT_W-1:0] shamt_q, shamt_d;
        logic [2:0]         op_q,    op_d;
        logic [TAG_W-1:0]   tag_q,   tag_d;
        logic               advance;

        // The slot may load whenever it is empty or its occupant leaves this cycle.
        assign advance = !vld_q || out_ready;

        always_comb begin
            vld_d   = vld_q;
            data_d  = data_q;
            shamt_d = shamt_q;
            op_d    = op_q;
            tag_d   = tag_q;
            if (advance) begin
                vld_d   = in_valid;
                data_d  = shifted;
                shamt_d = in_shamt;
                op_d    = in_op;
                tag_d   = in_tag;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                vld_q   <= 1'b0;
                data_q  <= '0;
                shamt_q <= '0;
                op_q    <= '0;
                tag_q   <= '0;
            end else begin
                vld_q   <= vld_d;
                data_q  <= data_d;
                shamt_q <= shamt_d;
                op_q    <= op_d;
                tag_q   <= tag_d;
            end
        end

        assign in_ready  = advance;
        assign out_valid = vld_q;
        assign out_data  = data_q;
        assign out_shamt = shamt_q;
        assign out_op    = op_q;
        assign out_tag   = tag_q;
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk = clock ^ reset_n;

        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign out_data  = shifted;
        assign out_shamt = in_shamt;
        assign out_op    = in_op;
        assign out_tag   = in_tag;
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Parametrised shift/rotate unit built from log stages, each optionally registered,
// with valid/ready backpressure and a tag returned alongside each result.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W = 5,
    parameter logic [SHAMT_W-1:0] REG_STAGES = {SHAMT_W{1'b1}}
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    // Index k is the input of stage k; index SHAMT_W is the block output.
    logic               vld_s   [SHAMT_W+1];
    logic               rdy_s   [SHAMT_W+1];
    logic [WIDTH-1:0]   data_s  [SHAMT_W+1];
    logic [SHAMT_W-1:0] shamt_s [SHAMT_W+1];
    logic [2:0]         op_s    [SHAMT_W+1];
    logic [TAG_W-1:0]   tag_s   [SHAMT_W+1];

    assign vld_s[0]        = in_valid;
    assign data_s[0]       = in_data;
    assign shamt_s[0]      = in_shamt;
    assign op_s[0]         = in_op;
    assign tag_s[0]        = in_tag;
    assign in_ready        = rdy_s[0];
    assign rdy_s[SHAMT_W]  = out_ready;
    assign out_valid       = vld_s[SHAMT_W];
    assign out_data        = data_s[SHAMT_W];
    assign out_tag         = tag_s[SHAMT_W];

    logic unused_tail;
    assign unused_tail = ^{op_s[SHAMT_W], shamt_s[SHAMT_W]};

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shifter_stage #(
            .WIDTH      (WIDTH),
            .TAG_W      (TAG_W),
            .DIST       (2 ** k),
            .REGISTERED (REG_STAGES[k])
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .in_valid  (vld_s[k]),
            .in_ready  (rdy_s[k]),
            .in_data   (data_s[k]),
            .in_shamt  (shamt_s[k]),
            .in_op     (op_s[k]),
            .in_tag    (tag_s[k]),
            .out_valid (vld_s[k+1]),
            .out_ready (rdy_s[k+1]),
            .out_data  (data_s[k+1]),
            .out_shamt (shamt_s[k+1]),
            .out_op    (op_s[k+1]),
            .out_tag   (tag_s[k+1])
        );
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for the barrel shifter: a 3-stage-latency instance and a combinational one.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    localparam logic [4:0] REGS = 5'b10101;
    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] in_data = '0, out_data;
    logic [4:0]  in_shamt = '0, in_tag = '0, out_tag;
    logic [2:0]  in_op = '0;

    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1;
    logic [31:0] c_in_data = '0, c_out_data;
    logic [4:0]  c_in_shamt = '0, c_in_tag = '0, c_out_tag;
    logic [2:0]  c_in_op = '0;

    always #5 clock = ~clock;

    pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(5), .REG_STAGES(REGS)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(5), .REG_STAGES(5'b00000)) dut_comb (
        .clock(clock), .reset_n(reset_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .in_shamt(c_in_shamt), .in_op(c_in_op), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_tag(c_out_tag)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          acc_cycle;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cycle = 0;
    bit   chk_lat = 1'b0;
    int   first_pop = -1;
    int   last_pop = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cycle);
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                          input logic [2:0] op);
        logic [63:0] dd;
        logic signed [31:0] ds;
        dd = {d, d};
        ds = d;
        case (op)
            3'd0: model = d << s;
            3'd1: model = d >> s;
            3'd2: model = ds >>> s;
            3'd3: begin dd = dd << s; model = dd[63:32]; end
            3'd4: begin dd = dd >> s; model = dd[31:0]; end
            default: model = d;
        endcase
    endfunction

    always @(posedge clock) cycle <= cycle + 1;

    // Acceptance pushes to the scoreboard; every visible result is compared to the queue head.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        if (e.chk_lat) check("latency", cycle - e.acc_cycle, LAT);
                        if (first_pop < 0) first_pop = cycle;
                        last_pop = cycle;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.data = model(in_data, in_shamt, in_op);
                e.tag = in_tag;
                e.acc_cycle = cycle;
                e.chk_lat = chk_lat;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [2:0] op,
                        input logic [4:0] tag);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op; in_tag = tag;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [31:0] dv [6] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                                32'h0000_00F1, 32'h8000_0001, 32'h1234_5678};
        logic [4:0]  sv [6] = '{5'd31, 5'd4, 5'd4, 5'd4, 5'd1, 5'd9};
        logic [2:0]  ov [6] = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b011, 3'b111};
        logic [31:0] ev [6] = '{32'h8000_0000, 32'hF800_0000, 32'h0800_0000,
                                32'h1000_000F, 32'h0000_0003, 32'h1234_5678};

        check("popcount_latency", popcount(32'(REGS)), LAT);
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Directed vectors with latency tracking; the model result is cross-checked with known answers.
        chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("model_vector", model(dv[i], sv[i], ov[i]), ev[i]);
            send(dv[i], sv[i], ov[i], 5'(i));
            drain();
        end

        // Back-to-back stream of 8.
        first_pop = -1;
        for (int i = 0; i < 8; i++) begin
            send($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 5'(i));
        end
        drain();
        check("stream_span", last_pop - first_pop, 7);
        chk_lat = 1'b0;

        // Backpressure with in_valid held.
        acc = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_ROL; in_shamt = 5'd7; in_data = $urandom; in_tag = 5'd10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (in_ready) acc++;
            @(posedge clock);
            #1;
            in_tag = 5'(10 + acc);
            in_data = $urandom;
        end
        check("bp_accepts", acc, 3);
        @(negedge clock);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);

        // Full pipe: output and input accepted in the same cycle.
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        check("full_same_cycle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("full_still_full", 32'(in_ready), 32'd0);
        check("occupancy", 32'(exp_q.size()), 32'd3);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset with two requests in flight.
        send(32'hDEAD_BEEF, 5'd3, OP_SLL, 5'd20);
        send(32'hCAFE_F00D, 5'd5, OP_SRA, 5'd21);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_out_data", out_data, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("no_stale_result", 32'(out_valid), 32'd0);
        end
        send(32'h0000_00F0, 5'd4, OP_SRL, 5'd22);
        drain();

        // Combinational variant.
        c_in_valid = 1'b1; c_in_data = 32'h0000_00FF; c_in_shamt = 5'd8; c_in_op = OP_SLL;
        c_in_tag = 5'd9; c_out_ready = 1'b1;
        #1;
        check("comb_data", c_out_data, 32'h0000_FF00);
        check("comb_tag", 32'(c_out_tag), 32'd9);
        check("comb_out_valid", 32'(c_out_valid), 32'd1);
        check("comb_in_ready_hi", 32'(c_in_ready), 32'd1);
        c_out_ready = 1'b0;
        c_in_data = 32'hF000_0000; c_in_shamt = 5'd8; c_in_op = OP_SRA;
        #1;
        check("comb_in_ready_lo", 32'(c_in_ready), 32'd0);
        check("comb_sra", c_out_data, model(32'hF000_0000, 5'd8, OP_SRA));
        c_in_valid = 1'b0;
        #1;
        check("comb_out_valid_lo", 32'(c_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
